// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter from NrPorts requesters onto one in-order memory port
// Optional sticky protocol checker compiled in with MEM_ARB_ERR_CHECK_EN.
module mem_port_arbiter #(
    parameter int NrPorts        = 3,
    parameter int AddrWidth      = 64,
    parameter int DataWidth      = 64,
    parameter int MaxOutstanding = 7
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NrPorts-1:0]             req_valid_i,
    output logic [NrPorts-1:0]             req_ready_o,
    input  logic [NrPorts*AddrWidth-1:0]   req_addr_i,
    input  logic [NrPorts-1:0]             req_we_i,
    input  logic [NrPorts*DataWidth-1:0]   req_wdata_i,
    output logic [NrPorts-1:0]             rsp_valid_o,
    output logic [DataWidth-1:0]           rsp_rdata_o,
    output logic                           mem_req_valid_o,
    input  logic                           mem_req_ready_i,
    output logic [AddrWidth-1:0]           mem_req_addr_o,
    output logic                           mem_req_we_o,
    output logic [DataWidth-1:0]           mem_req_wdata_o,
    input  logic                           mem_rsp_valid_i,
    input  logic [DataWidth-1:0]           mem_rsp_rdata_i,
    output logic                           err_o
);
    localparam int IdxW = $clog2(NrPorts);
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW = $clog2(MaxOutstanding + 1);

    typedef enum logic {IDLE, HOLD} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     hold_q, hold_d;
    logic [IdxW-1:0]     last_q, last_d;
    logic [IdxW-1:0]     id_fifo_q [MaxOutstanding];
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]     count_q;

    logic [IdxW-1:0]     rr_idx;
    logic                rr_found;
    logic [IdxW-1:0]     winner;
    logic                full;
    logic                grant_ok;
    logic                handshake;
    logic                pop;

    function automatic logic [IdxW-1:0] rr_cand(input logic [IdxW-1:0] last, input int off);
        int s;
        s = int'(last) + off;
        if (s >= NrPorts) s = s - NrPorts;
        return IdxW'(s);
    endfunction

    // Scan downward so the candidate closest to last_grant+1 is the one left standing.
    always_comb begin
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int i = NrPorts; i >= 1; i--) begin
            if (req_valid_i[rr_cand(last_q, i)]) begin
                rr_idx   = rr_cand(last_q, i);
                rr_found = 1'b1;
            end
        end
    end

    assign full     = (count_q == CntW'(MaxOutstanding));
    assign grant_ok = rr_found && !full;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            hold_q  <= '0;
            last_q  <= IdxW'(NrPorts - 1);
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (grant_ok && !mem_req_ready_i) begin
                    state_d = HOLD;
                    hold_d  = rr_idx;
                end
            end
            HOLD: begin
                if (mem_req_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        winner          = (state_q == HOLD) ? hold_q : rr_idx;
        mem_req_valid_o = !rst_i && ((state_q == HOLD) || grant_ok);
        handshake       = mem_req_valid_o && mem_req_ready_i;
        req_ready_o     = handshake ? (NrPorts'(1) << winner) : '0;
        mem_req_addr_o  = req_addr_i[winner*AddrWidth +: AddrWidth];
        mem_req_wdata_o = req_wdata_i[winner*DataWidth +: DataWidth];
        mem_req_we_o    = req_we_i[winner];
        last_d          = handshake ? winner : last_q;
        pop             = !rst_i && mem_rsp_valid_i && (count_q != '0);
        rsp_valid_o     = pop ? (NrPorts'(1) << id_fifo_q[rd_ptr_q]) : '0;
        rsp_rdata_o     = mem_rsp_rdata_i;
    end

    // In-order ID FIFO: which requester each outstanding response belongs to.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (handshake) begin
                wr_ptr_q <= (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (handshake && !pop) count_q <= count_q + 1'b1;
            else if (!handshake && pop) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && handshake) id_fifo_q[wr_ptr_q] <= winner;
    end

`ifdef MEM_ARB_ERR_CHECK_EN
    logic err_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if ((mem_rsp_valid_i && count_q == '0) ||
                     (state_q == HOLD && !req_valid_i[hold_q])) begin
            err_q <= 1'b1;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif
endmodule
